// File: rtl/avg_iir_filter.sv
// One-pole exponential moving average: y <= y + (x - y) * 2^-k on each accepted sample.
// Accumulator carries GUARD_BITS of extra fraction; output is rounded half up and saturated.
module avg_iir_filter #(
  parameter int DATA_WIDTH  = 24,
  parameter int GUARD_BITS  = 8,
  parameter int MAX_SHIFT   = 15,
  parameter int SHIFT_WIDTH = $clog2(MAX_SHIFT + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic [SHIFT_WIDTH-1:0]       i_shift,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_valid,
  output logic signed [DATA_WIDTH-1:0] o_data
);

  localparam int AW = DATA_WIDTH + GUARD_BITS;
  localparam logic [AW:0] HALF = (AW + 1)'(1) << (GUARD_BITS - 1);

  // Stream handshake: a sample is taken on every rising edge where i_valid=1
  // and i_clear=0 (no backpressure); o_valid pulses for one cycle one edge later.

  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         acc_next;
  logic signed [AW:0]           x_ext;
  logic signed [AW:0]           diff;
  logic signed [AW:0]           step;
  logic signed [AW:0]           sum;
  logic signed [AW:0]           rnd;
  logic        [SHIFT_WIDTH-1:0] k;
  logic signed [DATA_WIDTH:0]   y_round;
  logic signed [DATA_WIDTH-1:0] y_sat;

  always_comb begin
    k = (i_shift > SHIFT_WIDTH'(MAX_SHIFT)) ? SHIFT_WIDTH'(MAX_SHIFT) : i_shift;
    x_ext = {i_data[DATA_WIDTH-1], i_data, {GUARD_BITS{1'b0}}};
    // One extra bit of headroom so x - acc cannot wrap.
    diff     = x_ext - {acc[AW-1], acc};
    step     = diff >>> k;
    sum      = {acc[AW-1], acc} + step;
    acc_next = sum[AW-1:0];
    rnd      = sum + HALF;
    y_round  = rnd[AW:GUARD_BITS];
    if (y_round[DATA_WIDTH] != y_round[DATA_WIDTH-1])
      y_sat = y_round[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      y_sat = y_round[DATA_WIDTH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_valid) begin
      acc     <= acc_next;
      o_data  <= y_sat;
      o_valid <= 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_iir_filter.sv
// Directed bench for avg_iir_filter: driver pushes hand-computed outputs into a queue,
// a monitor pops and compares on each o_valid pulse.
module tb_avg_iir_filter;

  localparam int DW = 24;
  localparam int GB = 8;
  localparam int MS = 14;
  localparam int SW = $clog2(MS + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 valid = 1'b0;
  logic [SW-1:0]        shift = '0;
  logic signed [DW-1:0] data = '0;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  avg_iir_filter #(
    .DATA_WIDTH(DW), .GUARD_BITS(GB), .MAX_SHIFT(MS), .SHIFT_WIDTH(SW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_shift(shift),
    .i_valid(valid), .i_data(data), .o_valid(o_valid), .o_data(o_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // driver tasks
  task automatic send(input int k, input int x, input int expv);
    @(negedge clk);
    clear = 1'b0;
    shift = SW'(k);
    data  = DW'(x);
    valid = 1'b1;
    exp_q.push_back(DW'(expv));
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_o_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("o_data", o_data, $signed(e));
        end
      end
    end
  end

  initial begin
    // reset state
    #1;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_data", o_data, 0);
    check("reset_acc", dut.acc, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // step response, k=2
    send(2, 1000, 250);
    send(2, 1000, 438);
    send(2, 1000, 578);
    send(2, 1000, 684);
    send(2, 1000, 763);

    // asynchronous reset mid-stream, between edges, with i_valid still high
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_o_valid", o_valid, 0);
    check("midreset_o_data", o_data, 0);
    check("midreset_acc", dut.acc, 0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_no_pulse", o_valid, 0);

    // pass-through, k=0, including full-scale extremes
    send(0, -5, -5);
    send(0, 8388607, 8388607);
    send(0, -8388608, -8388608);
    idle();

    // small negative input, k=2: acc -64, -112, -148
    do_clear();
    send(2, -1, 0);
    send(2, -1, 0);
    send(2, -1, -1);
    idle();

    // clear has priority over a simultaneous sample
    do_clear();
    send(3, 4000, 500);
    send(3, 4000, 938);
    @(negedge clk);
    clear = 1'b1;
    valid = 1'b1;
    data  = DW'(4000);
    @(posedge clk);
    #1;
    check("clear_o_valid", o_valid, 0);
    check("clear_o_data", o_data, 0);
    check("clear_acc", dut.acc, 0);
    send(3, 4000, 500);
    idle();

    // all-ones shift clamps to MAX_SHIFT=14 (k=15 would give 256 first)
    do_clear();
    send(15, 8388607, 512);
    send(15, 8388607, 1024);
    idle();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_o_valid", o_valid, 0);
      check("idle_o_data", o_data, 1024);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_iir_filter.md
# avg_iir_filter

Single-channel exponential moving-average (first-order IIR low-pass) filter for signed audio samples in the Filters chain. Each accepted sample updates an internal accumulator by y ← y + (x − y)·2^−k, with k selectable at run time. It provides one-pole smoothing for level detection, parameter de-zippering and DC tracking between stream producers and consumers on the system clock.

## Interface
- DATA_WIDTH, 24, width of signed two's-complement input and output samples
- GUARD_BITS, 8, extra fractional bits held in the accumulator
- MAX_SHIFT, 15, largest usable smoothing shift k
- SHIFT_WIDTH, $clog2(MAX_SHIFT+1), derived; width of i_shift

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous clear of filter state
- i_shift  in  SHIFT_WIDTH  smoothing shift k; values above MAX_SHIFT are clamped to MAX_SHIFT
- i_valid  in  1  input sample strobe
- i_data  in  DATA_WIDTH  signed input sample x
- o_valid  out  1  output sample strobe, one-cycle pulse per accepted input
- o_data  out  DATA_WIDTH  signed filtered sample y

## Operation
- Accumulator acc is signed, DATA_WIDTH+GUARD_BITS bits, and holds y scaled by 2^GUARD_BITS.
- On a rising edge with i_valid=1 and i_clear=0:
  - x_ext = i_data <<< GUARD_BITS.
  - diff = x_ext − acc, computed at DATA_WIDTH+GUARD_BITS+1 bits so it cannot overflow.
  - acc ← acc + (diff >>> k), using an arithmetic shift (floor toward −∞).
  - k = min(i_shift, MAX_SHIFT), sampled on the same edge.
- The new acc always lies between the old acc and x_ext, so acc never overflows.
- Output: o_data ← sat((acc_new + 2^(GUARD_BITS−1)) >>> GUARD_BITS), i.e. round half up, then saturate to the DATA_WIDTH signed range.
  - Saturation is a defensive guard only; it is unreachable for legal state.
- k=0 gives a pure registered pass-through: acc = x_ext and o_data = i_data.
- A change of i_shift affects only later samples. acc is never disturbed by a shift change.
- i_clear=1 sets acc ← 0 and o_data ← 0, and forces o_valid ← 0.
  - Clear has priority over a simultaneous i_valid; that sample is discarded.
- With i_valid=0 and i_clear=0, acc and o_data hold their values and o_valid ← 0.
- No backpressure: every valid sample is accepted, so the block sustains one sample per clock.
- Arithmetic is fully combinational between input and the output register. There is no multi-cycle state machine.

## Timing
- Reset (i_rst_n=0, asynchronous assert): acc=0, o_data=0, o_valid=0 immediately, independent of the clock.
- Reset release is synchronized by the surrounding system. The first sample is accepted on the first edge with i_rst_n=1.
- Latency is 1 cycle: i_valid sampled at edge n produces o_valid=1 and the updated o_data after edge n.
- o_valid is high for exactly one cycle per accepted sample. Back-to-back inputs give back-to-back outputs.
- o_data remains stable between o_valid pulses.
- Reset asserted mid-stream discards in-flight state. No output pulse follows for a sample presented on the reset edge.
- A simultaneous i_clear and i_valid yields o_valid=0 on the next cycle, with acc=0.

## Test plan
- Reset: assert i_rst_n=0 mid-stream, between clock edges. Required: o_valid=0, o_data=0 and acc=0 at once, before the next edge.
- Step, k=2: hold i_data=1000 with i_valid=1 from reset. Required: o_data sequence 250, 438, 578, 684, … converging to 1000. o_valid high each cycle after the first.
- Pass-through, k=0: feed −5, 8388607, −8388608. Required: outputs are identical, each one cycle later, with no overflow.
- Small negative, k=2: from reset, feed i_data=−1 once. Required: o_data=0 (acc=−64 rounds to 0).
  - A second −1 gives acc=−112, so o_data=0.
  - Continue until o_data=−1; this checks arithmetic-shift and rounding behaviour.
- Clear priority: during a k=3 stream at o_data≠0, drive i_clear=1 together with i_valid=1 and i_data=4000. Required: next-cycle o_valid=0 and o_data=0.
  - The following sample of 4000 gives o_data=500.
- Shift clamp and idle hold: set i_shift to its all-ones value with MAX_SHIFT=14 (SHIFT_WIDTH=4). Required: behaves as k=14.
  - Gap i_valid for 10 cycles. Required: o_data holds and o_valid stays 0.
